// File: rtl/sseg_mux_counter.sv
// sseg_mux_counter: DIGITS-wide BCD up/down counter with prescaled stepping,
// synchronous clamped load, wrap pulse, and a time-multiplexed active-low
// seven-segment driver for a common-anode display.
//
// Optional feature macro: SSEG_LZB_EN (leading-zero blanking). When defined,
// digits above index 0 that are zero along with every more-significant digit
// are driven blank; dig scanning is unchanged.

// Per-digit cell: ripple step, load clamp and segment decode for one digit.
module sseg_bcd_cell (
  input  logic [3:0] d,
  input  logic       up,
  input  logic       cin,
  input  logic [3:0] ld,
  output logic [3:0] nxt,
  output logic       cout,
  output logic [3:0] ld_sat,
  output logic [7:0] pat
);

  // Ripple step: this digit moves only when every lower digit rolled over.
  always_comb begin
    nxt  = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end

  // Non-BCD load digits saturate to 9.
  always_comb begin
    ld_sat = (ld > 4'd9) ? 4'd9 : ld;
  end

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp always off.
  always_comb begin
    case (d)
      4'd0:    pat = 8'hC0;
      4'd1:    pat = 8'hF9;
      4'd2:    pat = 8'hA4;
      4'd3:    pat = 8'hB0;
      4'd4:    pat = 8'h99;
      4'd5:    pat = 8'h92;
      4'd6:    pat = 8'h82;
      4'd7:    pat = 8'hF8;
      4'd8:    pat = 8'h80;
      4'd9:    pat = 8'h90;
      default: pat = 8'hFF;
    endcase
  end

endmodule

module sseg_mux_counter #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int COUNT_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

  localparam logic [PW-1:0] PRE_MAX  = PW'(COUNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] val_q, val_nxt, ld_sat;
  logic [DIGITS-1:0][7:0] pat;
  logic [DIGITS:0]        carry;
  logic [PW-1:0]          pre;
  logic [SW-1:0]          sc;
  logic [IW-1:0]          idx;
  logic [7:0]             seg_nxt;
  logic [DIGITS-1:0]      dig_nxt;

  assign carry[0] = 1'b1;
  assign value    = val_q;

  // One cell per digit; carry[DIGITS] means the whole count rolled over.
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      sseg_bcd_cell u_cell (
        .d      (val_q[g]),
        .up     (up),
        .cin    (carry[g]),
        .ld     (load_val[4*g +: 4]),
        .nxt    (val_nxt[g]),
        .cout   (carry[g+1]),
        .ld_sat (ld_sat[g]),
        .pat    (pat[g])
      );
    end
  endgenerate

`ifdef SSEG_LZB_EN
  // zhi[i]: digit i and everything above it are zero.
  logic [DIGITS-1:0] zhi;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_zhi
      if (g == DIGITS - 1) begin : g_top
        assign zhi[g] = (val_q[g] == 4'd0);
      end else begin : g_lo
        assign zhi[g] = (val_q[g] == 4'd0) && zhi[g+1];
      end
    end
  endgenerate
`endif

  // Count state: load beats a prescaler step; wrap is a one-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      pre   <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      val_q <= ld_sat;
      pre   <= '0;
      wrap  <= 1'b0;
    end else if (en) begin
      if (pre == PRE_MAX) begin
        pre   <= '0;
        val_q <= val_nxt;
        wrap  <= carry[DIGITS];
      end else begin
        pre  <= pre + 1'b1;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  // Free-running scan timer; advances the active digit at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc  <= '0;
      idx <= '0;
    end else if (sc == SCAN_MAX) begin
      sc  <= '0;
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      sc <= sc + 1'b1;
    end
  end

  // Pick the pattern and anode for the current slot from this cycle's state.
  always_comb begin
    seg_nxt = pat[idx];
`ifdef SSEG_LZB_EN
    if (idx != '0 && zhi[idx]) seg_nxt = 8'hFF;
`endif
    dig_nxt = ~(DIGITS'(1) << idx);
  end

  // seg and dig registered together so a slot never pairs the wrong digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 8'hFF;
      dig <= '1;
    end else begin
      seg <= seg_nxt;
      dig <= dig_nxt;
    end
  end

endmodule

// File: tb/tb_sseg_mux_counter.sv
// Bench for sseg_mux_counter (DIGITS=4, SCAN_DIV=4, COUNT_DIV=3).
// Integer-valued reference model plus directed literal checks.
module tb_sseg_mux_counter;

  localparam int DIGITS = 4;
  localparam int SDIV   = 4;
  localparam int CDIV   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en, up, load;
  logic [15:0] load_val;
  logic [15:0] value;
  logic        wrap;
  logic [7:0]  seg;
  logic [3:0]  dig;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // reference state
  int         mval = 0;
  int         mpre = 0;
  int         mcyc = 0;
  bit         mwrap = 1'b0;
  logic [7:0] mseg = 8'hFF;
  logic [3:0] mdig = 4'hF;

  sseg_mux_counter #(.DIGITS(DIGITS), .SCAN_DIV(SDIV), .COUNT_DIV(CDIV)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .value(value), .wrap(wrap), .seg(seg), .dig(dig)
  );

  always #5 clk = ~clk;

  function automatic string lit(int d);
    case (d)
      0: return "abcdef";
      1: return "bc";
      2: return "abdeg";
      3: return "abcdg";
      4: return "bcfg";
      5: return "acdfg";
      6: return "acdefg";
      7: return "abc";
      8: return "abcdefg";
      default: return "abcdfg";
    endcase
  endfunction

  function automatic logic [7:0] pat(int d);
    string s;
    logic [7:0] r;
    s = lit(d);
    r = 8'hFF;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  function automatic int pow10(int n);
    int p = 1;
    for (int i = 0; i < n; i++) p *= 10;
    return p;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic int from_ld(logic [15:0] lv);
    int v = 0;
    int nb;
    for (int i = 0; i < 4; i++) begin
      nb = int'(lv[4*i +: 4]);
      if (nb > 9) nb = 9;
      v += nb * pow10(i);
    end
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: count as a plain integer, scan slot from elapsed cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mval = 0; mpre = 0; mcyc = 0; mwrap = 1'b0;
      mseg = 8'hFF; mdig = 4'hF;
    end else begin
      int slot, p;
      slot = (mcyc / SDIV) % DIGITS;
      p = pow10(slot);
      mdig = ~(4'(1) << slot);
      mseg = pat((mval / p) % 10);
`ifdef SSEG_LZB_EN
      if (slot > 0 && mval < p) mseg = 8'hFF;
`endif
      mcyc++;
      mwrap = 1'b0;
      if (load) begin
        mval = from_ld(load_val);
        mpre = 0;
      end else if (en) begin
        if (mpre == CDIV - 1) begin
          mpre = 0;
          if (up) begin
            mwrap = (mval == 9999);
            mval  = (mval + 1) % 10000;
          end else begin
            mwrap = (mval == 0);
            mval  = (mval + 9999) % 10000;
          end
        end else begin
          mpre++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model value", 32'(value), 32'(to_bcd(mval)));
      cmp("model wrap",  32'(wrap),  32'(mwrap));
      cmp("model seg",   32'(seg),   32'(mseg));
      cmp("model dig",   32'(dig),   32'(mdig));
    end
  end

  task automatic do_load(logic [15:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] scan_exp [4];
    logic [7:0] hi_blank;
    scan_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;

    // async reset
    #1 rst = 1'b1;
    #1;
    cmp("reset seg", 32'(seg), 32'hFF);
    cmp("reset dig", 32'(dig), 32'hF);
    cmp("reset value", 32'(value), 32'h0);
    cmp("reset wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // scan with en=0
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      cmp("scan dig", 32'(dig), 32'(scan_exp[(k-1)/4]));
      cmp("scan seg", 32'(seg), 32'hC0);
      cmp("scan value", 32'(value), 32'h0);
    end

    // 0998 -> 0999 -> 1000
    do_load(16'h0998);
    en = 1'b1; up = 1'b1;
    cmp("load 0998", 32'(value), 32'h0998);
    repeat (3) @(negedge clk);
    cmp("inc 0999", 32'(value), 32'h0999);
    cmp("inc wrap0", 32'(wrap), 32'h0);
    repeat (3) @(negedge clk);
    cmp("inc 1000", 32'(value), 32'h1000);
    cmp("inc wrap1", 32'(wrap), 32'h0);

    // 9999 wraps up
    load = 1'b1;
    do_load(16'h9999);
    repeat (2) @(negedge clk);
    cmp("hold 9999", 32'(value), 32'h9999);
    @(negedge clk);
    cmp("up wrap value", 32'(value), 32'h0000);
    cmp("up wrap pulse", 32'(wrap), 32'h1);
    @(negedge clk);
    cmp("up wrap end", 32'(wrap), 32'h0);

    // 0000 wraps down
    up = 1'b0;
    do_load(16'h0000);
    repeat (3) @(negedge clk);
    cmp("down wrap value", 32'(value), 32'h9999);
    cmp("down wrap pulse", 32'(wrap), 32'h1);
    @(negedge clk);
    cmp("down wrap end", 32'(wrap), 32'h0);

    // clamp and display of 0093
    en = 1'b0; up = 1'b1;
    do_load(16'h00F3);
    cmp("clamp value", 32'(value), 32'h0093);
`ifdef SSEG_LZB_EN
    hi_blank = 8'hFF;
`else
    hi_blank = 8'hC0;
`endif
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      case (dig)
        4'b1110: cmp("slot0 seg", 32'(seg), 32'hB0);
        4'b1101: cmp("slot1 seg", 32'(seg), 32'h90);
        4'b1011: cmp("slot2 seg", 32'(seg), 32'(hi_blank));
        4'b0111: cmp("slot3 seg", 32'(seg), 32'(hi_blank));
        default: cmp("slot dig onehot", 32'(dig), 32'hE);
      endcase
    end

    // en toggling: 2 high, 5 low, 1 high -> exactly one step
    do_load(16'h0000);
    en = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b0;
    cmp("toggle no early step", 32'(value), 32'h0);
    repeat (5) @(negedge clk);
    cmp("toggle frozen", 32'(value), 32'h0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cmp("toggle step", 32'(value), 32'h0001);

    // reset mid-count, between clock edges
    en = 1'b1;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("midrst seg", 32'(seg), 32'hFF);
    cmp("midrst dig", 32'(dig), 32'hF);
    cmp("midrst value", 32'(value), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("post rst value", 32'(value), 32'h0);
    cmp("post rst dig", 32'(dig), 32'hE);
    cmp("post rst seg", 32'(seg), 32'hC0);
    repeat (4) @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
